alu_execute_stage: RTL and testbench

//  Registered execute stage downstream of the ALU control decoder. Accepts ALUControl,
//  two operands and a destination tag over a valid/ready handshake, computes the ALU

---
 rtl/alu_execute_stage.sv | 80 ++++++++
 tb/tb_alu_execute_stage.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/alu_execute_stage.sv
// alu_execute_stage: registered ALU execute stage with a 2-entry main/skid output buffer
module alu_execute_stage #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 5
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Flush,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       ALUControl,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [TAG_W-1:0] InTag,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero,
  output logic             Overflow,
  output logic             IllegalOp,
  output logic [TAG_W-1:0] OutTag
);
  localparam int E = WIDTH + TAG_W + 3;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  state_t state, state_nx;
  logic [E-1:0] main_q, skid_q, ent;
  logic [WIDTH-1:0] sum, diff, res;
  logic in_ready_q, acc, deq, lt, is_add, is_sub, ill, ovf;
  logic load_new, load_skid, skid_to_main;
  assign sum = SrcA + SrcB;
  assign diff = SrcA - SrcB;
  assign lt = $signed(SrcA) < $signed(SrcB);
  assign is_add = ALUControl == 3'b010;
  assign is_sub = ALUControl == 3'b110;
  assign ill = ALUControl == 3'b011 || ALUControl == 3'b100 || ALUControl == 3'b101;
  always_comb begin
    res = is_add ? sum :
          is_sub ? diff :
          (ALUControl == 3'b000) ? (SrcA & SrcB) :
          (ALUControl == 3'b001) ? (SrcA | SrcB) :
          (ALUControl == 3'b111) ? {{(WIDTH-1){1'b0}}, lt} : '0;
    ovf = is_add ? (SrcA[WIDTH-1] == SrcB[WIDTH-1] && sum[WIDTH-1] != SrcA[WIDTH-1]) :
          is_sub ? (SrcA[WIDTH-1] != SrcB[WIDTH-1] && diff[WIDTH-1] != SrcA[WIDTH-1]) : 1'b0;
    ent = {ill, ovf, res == '0, InTag, res};
  end
  // InReady comes straight from a flop so OutReady never reaches it combinationally
  assign InReady = in_ready_q;
  assign OutValid = state != EMPTY;
  assign acc = InValid && in_ready_q && !Flush;
  assign deq = OutValid && OutReady;
  assign load_new = acc && (state == EMPTY || deq);
  assign load_skid = acc && state == ONE && !deq;
  assign skid_to_main = state == TWO && deq;
  always_comb begin
    state_nx = Flush ? EMPTY :
               (state == EMPTY) ? (acc ? ONE : EMPTY) :
               (state == ONE) ? ((acc && !deq) ? TWO : (deq && !acc) ? EMPTY : ONE) :
               (deq ? ONE : TWO);
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state <= state_nx;
      in_ready_q <= state_nx != TWO;
    end
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (load_new) main_q <= ent;
      else if (skid_to_main) main_q <= skid_q;
      if (load_skid) skid_q <= ent;
    end
  end
  assign {IllegalOp, Overflow, Zero, OutTag, ALUResult} = main_q;
endmodule

// File: tb/tb_alu_execute_stage.sv
// tb_alu_execute_stage: directed and random checks of alu_execute_stage against a queue-based model
module tb_alu_execute_stage;
  logic CLK = 0, RST = 1, Flush = 0, InValid = 0, OutReady = 0;
  logic [2:0] ALUControl = 0;
  logic [31:0] SrcA = 0, SrcB = 0, ALUResult;
  logic [4:0] InTag = 0, OutTag;
  logic InReady, OutValid, Zero, Overflow, IllegalOp;
  int total = 0, bad = 0, accepted;
  logic acc;
  typedef struct {logic [31:0] r; logic z, o, i; logic [4:0] t;} ent_t;
  ent_t q[$];
  logic [4:0] seen[$];

  alu_execute_stage #(.WIDTH(32), .TAG_W(5)) dut (
    .CLK(CLK), .RST(RST), .Flush(Flush), .InValid(InValid), .InReady(InReady),
    .ALUControl(ALUControl), .SrcA(SrcA), .SrcB(SrcB), .InTag(InTag),
    .OutValid(OutValid), .OutReady(OutReady), .ALUResult(ALUResult), .Zero(Zero),
    .Overflow(Overflow), .IllegalOp(IllegalOp), .OutTag(OutTag)
  );

  always #5 CLK = ~CLK;

  function automatic ent_t model(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    ent_t e;
    longint sa = longint'($signed(a)), sb = longint'($signed(b)), s;
    e = '{r: 0, z: 0, o: 0, i: 0, t: t};
    case (op)
      3'b010: begin s = sa + sb; e.r = s[31:0]; e.o = s > 64'sd2147483647 || s < -64'sd2147483648; end
      3'b110: begin s = sa - sb; e.r = s[31:0]; e.o = s > 64'sd2147483647 || s < -64'sd2147483648; end
      3'b000: e.r = a & b;
      3'b001: e.r = a | b;
      3'b111: e.r = (sa < sb) ? 32'd1 : 32'd0;
      default: e.i = 1;
    endcase
    e.z = e.r == 0;
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // one clock: check outputs against the model before the edge, then advance the model
  task automatic step();
    ent_t e;
    @(negedge CLK);
    chk("out_valid", OutValid, q.size() != 0);
    chk("in_ready", InReady, q.size() != 2);
    if (OutValid && q.size() > 0) begin
      e = q[0];
      chk("result", ALUResult, e.r);
      chk("zero", Zero, e.z);
      chk("overflow", Overflow, e.o);
      chk("illegal", IllegalOp, e.i);
      chk("tag", OutTag, e.t);
    end
    acc = 0;
    if (Flush) q.delete();
    else begin
      if (OutValid && OutReady && q.size() > 0) seen.push_back(q.pop_front().t);
      if (InValid && InReady) begin
        q.push_back(model(ALUControl, SrcA, SrcB, InTag));
        acc = 1;
      end
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(logic [2:0] op, logic [31:0] a, logic [31:0] b, logic [4:0] t);
    ALUControl = op; SrcA = a; SrcB = b; InTag = t; InValid = 1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h7fffffff;
      2: return 32'h80000000;
      3: return 32'hffffffff;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    repeat (2) @(posedge CLK);
    #1 RST = 0;
    chk("rst_out_valid", OutValid, 0);
    chk("rst_in_ready", InReady, 1);
    chk("rst_result", ALUResult, 0);
    chk("rst_zero", Zero, 0);
    chk("rst_overflow", Overflow, 0);
    chk("rst_illegal", IllegalOp, 0);
    chk("rst_tag", OutTag, 0);
    OutReady = 1;
    drive(3'b010, 32'h7fffffff, 32'h1, 5'd3); step(); InValid = 0;
    chk("add_result", ALUResult, 32'h80000000);
    chk("add_overflow", Overflow, 1);
    chk("add_zero", Zero, 0);
    chk("add_tag", OutTag, 3);
    drive(3'b110, 32'd5, 32'd5, 5'd4); step(); InValid = 0;
    chk("sub_result", ALUResult, 0);
    chk("sub_zero", Zero, 1);
    drive(3'b111, 32'h80000000, 32'h1, 5'd5); step(); InValid = 0;
    chk("slt_neg", ALUResult, 1);
    drive(3'b111, 32'h1, 32'hffffffff, 5'd6); step(); InValid = 0;
    chk("slt_pos", ALUResult, 0);
    step();
    // backpressure: t1,t2 fill the buffer, t3 must be held until space opens
    OutReady = 0;
    seen.delete();
    drive(3'b001, 32'h0f, 32'hf0, 5'd11); step();
    drive(3'b000, 32'hff, 32'h3c, 5'd12); step();
    chk("bp_in_ready_low", InReady, 0);
    drive(3'b010, 32'd1, 32'd2, 5'd13);
    step(); step();
    OutReady = 1;
    acc = 0;
    for (int i = 0; i < 10 && !acc; i++) step();
    chk("bp_t3_accepted", acc, 1);
    InValid = 0;
    repeat (5) step();
    chk("bp_count", seen.size(), 3);
    if (seen.size() == 3) begin
      chk("bp_order0", seen[0], 11);
      chk("bp_order1", seen[1], 12);
      chk("bp_order2", seen[2], 13);
    end
    // flush while full with a new op offered
    OutReady = 0;
    drive(3'b010, 32'd7, 32'd8, 5'd20); step();
    drive(3'b010, 32'd9, 32'd1, 5'd21); step();
    drive(3'b010, 32'd3, 32'd3, 5'd22); Flush = 1; step();
    Flush = 0; InValid = 0;
    chk("flush_out_valid", OutValid, 0);
    chk("flush_in_ready", InReady, 1);
    OutReady = 1;
    repeat (3) step();
    drive(3'b100, 32'hffff, 32'hffff, 5'd9); step(); InValid = 0;
    chk("ill_result", ALUResult, 0);
    chk("ill_zero", Zero, 1);
    chk("ill_flag", IllegalOp, 1);
    step();
    accepted = 0;
    for (int c = 0; c < 60000 && accepted < 10000; c++) begin
      drive(3'($urandom_range(0, 7)), pick(), pick(), 5'($urandom));
      InValid = $urandom_range(0, 9) < 8;
      OutReady = $urandom_range(0, 9) < 7;
      Flush = $urandom_range(0, 999) == 0;
      step();
      if (acc) accepted++;
    end
    Flush = 0;
    chk("random_ops_done", accepted >= 10000, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
